// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: captures BCD adder operands/result and time-multiplexes them onto a 4-digit 7-segment display
module bcd_display_scanner #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] a_bcd,
   input  logic [3:0] b_bcd,
   input  logic [3:0] sum_bcd,
   input  logic       sum_cout,
   output logic [3:0] an_n,
   output logic [6:0] seg_n,
   output logic       dp_n
);
   localparam int CW = $clog2((REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES) + 1) + 1;
   typedef enum logic {DWELL, BLANK} phase_t;
   phase_t phase;
   logic [1:0] idx;
   logic [CW-1:0] cnt;
   logic [3:0] a_q, b_q, s_q;
   logic c_q;
   logic [6:0] cur_seg;
   logic dwell_end, blank_end;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: dec = 7'b1000000;
         4'd1: dec = 7'b1111001;
         4'd2: dec = 7'b0100100;
         4'd3: dec = 7'b0110000;
         4'd4: dec = 7'b0011001;
         4'd5: dec = 7'b0010010;
         4'd6: dec = 7'b0000010;
         4'd7: dec = 7'b1111000;
         4'd8: dec = 7'b0000000;
         4'd9: dec = 7'b0010000;
         default: dec = 7'b0000110;
      endcase
   endfunction

   always_comb begin
      cur_seg   = idx == 2'd0 ? dec(s_q) :
                  idx == 2'd1 ? (c_q ? 7'b1111001 : 7'h7F) :
                  idx == 2'd2 ? dec(b_q) : dec(a_q);
      dwell_end = phase == DWELL && cnt == CW'(REFRESH_DIV - 1);
      blank_end = phase == BLANK && cnt == CW'(BLANK_CYCLES - 1);
   end

   // outputs are registered from the state held before the edge, so the reset state counts as the first dwell cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_n  <= 4'hF;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         c_q   <= 1'b0;
         idx   <= '0;
         phase <= DWELL;
         cnt   <= '0;
      end else begin
         if (load) begin
            a_q <= a_bcd;
            b_q <= b_bcd;
            s_q <= sum_bcd;
            c_q <= sum_cout;
         end
         an_n  <= phase == DWELL ? ~(4'b0001 << idx) : 4'hF;
         seg_n <= phase == DWELL ? cur_seg : 7'h7F;
         dp_n  <= 1'b1;
         if (dwell_end) begin
            cnt <= '0;
            if (BLANK_CYCLES == 0) idx <= idx + 2'd1;
            else phase <= BLANK;
         end else if (blank_end) begin
            cnt   <= '0;
            phase <= DWELL;
            idx   <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed plus random stimulus checked every cycle against a period-arithmetic display model
module tb_bcd_display_scanner;
   logic clk = 0, rst_n = 0, load = 0, sum_cout = 0;
   logic [3:0] a_bcd = 0, b_bcd = 0, sum_bcd = 0;
   logic [3:0] an_n;
   logic [6:0] seg_n;
   logic dp_n;
   int passed = 0, total = 0;
   int n = 0;
   logic [6:0] lut [16];
   logic [3:0] ma = 0, mb = 0, ms = 0;
   logic mc = 0;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;

   bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .a_bcd(a_bcd), .b_bcd(b_bcd),
      .sum_bcd(sum_bcd), .sum_cout(sum_cout), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h at n=%0d", tag, obs, expv, n);
   endtask

   // each slot is 5 cycles: 4 lit, 1 blank; slot k lights digit k (0 = sum ones)
   task automatic tick();
      int p, slot;
      @(posedge clk);
      if (!rst_n) begin
         n = 0; ma = 0; mb = 0; ms = 0; mc = 0;
         exp_an = 4'hF; exp_seg = 7'h7F;
      end else begin
         n++;
         p = (n - 1) % 20;
         slot = p / 5;
         if (p % 5 == 4) begin
            exp_an = 4'hF; exp_seg = 7'h7F;
         end else begin
            exp_an = 4'hF;
            exp_an[slot] = 1'b0;
            case (slot)
               0: exp_seg = lut[ms];
               1: exp_seg = mc ? lut[1] : 7'h7F;
               2: exp_seg = lut[mb];
               default: exp_seg = lut[ma];
            endcase
         end
         if (load) begin ma = a_bcd; mb = b_bcd; ms = sum_bcd; mc = sum_cout; end
      end
      #1;
      chk("an_n", {4'h0, an_n}, {4'h0, exp_an});
      chk("seg_n", {1'b0, seg_n}, {1'b0, exp_seg});
      chk("dp_n", {7'h0, dp_n}, 8'h01);
   endtask

   task automatic ld(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input logic c);
      a_bcd = a; b_bcd = b; sum_bcd = s; sum_cout = c; load = 1;
      tick();
      load = 0;
   endtask

   initial begin
      lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
              7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
              7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};
      repeat (3) tick();
      rst_n = 1;
      repeat (12) tick();
      ld(4'd7, 4'd5, 4'd2, 1'b1);
      repeat (22) tick();
      ld(4'd3, 4'd4, 4'd7, 1'b0);
      repeat (22) tick();
      ld(4'd3, 4'd4, 4'b1100, 1'b0);
      repeat (22) tick();
      while (((n) % 20) != 1) tick();
      ld(4'd7, 4'd5, 4'd2, 1'b1);
      tick();
      ld(4'd7, 4'd5, 4'd9, 1'b1);
      repeat (20) tick();
      while (((n) % 20) != 12) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      repeat (22) tick();
      repeat (400) begin
         a_bcd = 4'($urandom_range(0, 15));
         b_bcd = 4'($urandom_range(0, 15));
         sum_bcd = 4'($urandom_range(0, 15));
         sum_cout = 1'($urandom_range(0, 1));
         load = $urandom_range(0, 3) == 0;
         rst_n = $urandom_range(0, 80) != 0;
         tick();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
